// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard stall/flush/freeze controller
//
// Purpose: decides, every cycle, which pipeline registers advance, which are
// loaded with a NOP, and when MEM/WB receives a bubble. It covers three cases:
// load-use hazards (1..LOAD_BUBBLES bubble cycles), taken branches resolved in
// EX (flush IF/ID and ID/EX), and data-memory wait states (freeze the whole
// pipe). It also counts the cycles in which the PC was held.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt                  ID-stage source register addresses
//   id_uses_rs, id_uses_rt        ID instruction really reads that source
//   ex_rd                         EX-stage destination register
//   ex_mem_read, ex_reg_write     EX instruction is a load / writes ex_rd
//   ex_branch_taken               EX resolved a taken branch/jump this cycle
//   mem_req, mem_ready            MEM stage access pending / completes now
//   pc_en, ifid_en, idex_en,
//   exmem_en                      pipeline register write enables
//   ifid_flush, idex_flush        load NOP into IF/ID, ID/EX
//   memwb_bubble                  load NOP into MEM/WB
//   lu_active                     controller is inside a multi-cycle load-use stall
//   stall_cycles                  saturating count of cycles with pc_en low

module hazard_control_unit #(
    parameter int LOAD_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  id_rs,
    input  logic [1:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [1:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        memwb_bubble,
    output logic        lu_active,
    output logic [15:0] stall_cycles
);

    // The first bubble is issued from RUN; LU_STALL covers the remaining ones.
    localparam logic [1:0] LU_CNT_INIT  = 2'(LOAD_BUBBLES - 1);
    localparam bit         MULTI_BUBBLE = (LOAD_BUBBLES > 1);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_LU_STALL = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [1:0]  r_lu_cnt;
    logic [1:0]  w_next_lu_cnt;
    logic [15:0] r_stall_cycles;

    logic w_load_use;
    logic w_mem_wait;

    logic w_pc_en;
    logic w_ifid_en;
    logic w_idex_en;
    logic w_exmem_en;
    logic w_ifid_flush;
    logic w_idex_flush;
    logic w_memwb_bubble;

    assign w_load_use = ex_mem_read & ex_reg_write &
                        ((id_uses_rs & (id_rs == ex_rd)) |
                         (id_uses_rt & (id_rt == ex_rd)));

    assign w_mem_wait = mem_req & ~mem_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_RUN;
            r_lu_cnt <= 2'd0;
        end else begin
            r_state  <= w_next_state;
            r_lu_cnt <= w_next_lu_cnt;
        end
    end

    // Next-state logic. A memory wait freezes the FSM exactly where it is.
    always_comb begin
        w_next_state  = r_state;
        w_next_lu_cnt = r_lu_cnt;
        if (!w_mem_wait) begin
            case (r_state)
                ST_RUN: begin
                    // A taken branch squashes the dependent ID instruction,
                    // so the hazard never materialises.
                    if (!ex_branch_taken && w_load_use && MULTI_BUBBLE) begin
                        w_next_state  = ST_LU_STALL;
                        w_next_lu_cnt = LU_CNT_INIT;
                    end
                end
                ST_LU_STALL: begin
                    if (r_lu_cnt == 2'd1) begin
                        w_next_state  = ST_RUN;
                        w_next_lu_cnt = 2'd0;
                    end else begin
                        w_next_lu_cnt = r_lu_cnt - 2'd1;
                    end
                end
                default: begin
                    w_next_state  = ST_RUN;
                    w_next_lu_cnt = 2'd0;
                end
            endcase
        end
    end

    // Output logic, in priority order: reset, memory wait, ongoing load-use
    // stall (EX holds a bubble, so a branch there is meaningless), taken
    // branch, new load-use hazard, normal flow.
    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_idex_en      = 1'b1;
        w_exmem_en     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_memwb_bubble = 1'b0;
        if (rst) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_memwb_bubble = 1'b1;
        end else if (w_mem_wait) begin
            w_pc_en        = 1'b0;
            w_ifid_en      = 1'b0;
            w_idex_en      = 1'b0;
            w_exmem_en     = 1'b0;
            w_memwb_bubble = 1'b1;
        end else if (r_state == ST_LU_STALL) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end else if (ex_branch_taken) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_flush = 1'b1;
        end
    end

    // A flush always wins over the write enable of the same register.
    assign pc_en        = w_pc_en;
    assign ifid_en      = w_ifid_en & ~w_ifid_flush;
    assign idex_en      = w_idex_en & ~w_idex_flush;
    assign exmem_en     = w_exmem_en;
    assign ifid_flush   = w_ifid_flush;
    assign idex_flush   = w_idex_flush;
    assign memwb_bubble = w_memwb_bubble;
    assign lu_active    = ~rst & (r_state == ST_LU_STALL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles <= 16'd0;
        end else if (!w_pc_en && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit

module tb_hazard_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] id_rs, id_rt, ex_rd;
    logic       id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write;
    logic       ex_branch_taken, mem_req, mem_ready;

    // Packed outputs: {pc_en, ifid_en, idex_en, exmem_en, ifid_flush,
    //                  idex_flush, memwb_bubble, lu_active}
    logic [7:0]  w_out   [3];
    logic [15:0] w_stall [3];

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining bubbles owed and stall count per instance.
    int         m_left  [3];
    int         m_stall [3];
    logic [7:0] m_exp   [3];
    logic       m_lu, m_mw;

    // Instance g uses LOAD_BUBBLES = g+1; all share the same stimulus.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_control_unit #(.LOAD_BUBBLES(g + 1)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .id_rs          (id_rs),
            .id_rt          (id_rt),
            .id_uses_rs     (id_uses_rs),
            .id_uses_rt     (id_uses_rt),
            .ex_rd          (ex_rd),
            .ex_mem_read    (ex_mem_read),
            .ex_reg_write   (ex_reg_write),
            .ex_branch_taken(ex_branch_taken),
            .mem_req        (mem_req),
            .mem_ready      (mem_ready),
            .pc_en          (w_out[g][7]),
            .ifid_en        (w_out[g][6]),
            .idex_en        (w_out[g][5]),
            .exmem_en       (w_out[g][4]),
            .ifid_flush     (w_out[g][3]),
            .idex_flush     (w_out[g][2]),
            .memwb_bubble   (w_out[g][1]),
            .lu_active      (w_out[g][0]),
            .stall_cycles   (w_stall[g])
        );
    end

    // Stimulus vector: {rst, rs, uses_rs, rt, uses_rt, rd, mem_read, reg_write,
    //                   branch, mem_req, mem_ready}
    localparam logic [13:0] V_IDLE   = 14'b0_00_0_00_0_00_0_0_0_0_0;
    localparam logic [13:0] V_RST    = 14'b1_00_0_00_0_00_0_0_0_0_0;
    localparam logic [13:0] V_LU     = 14'b0_10_1_00_0_10_1_1_0_0_0;
    localparam logic [13:0] V_LU_BR  = 14'b0_10_1_00_0_10_1_1_1_0_0;
    localparam logic [13:0] V_MW     = 14'b0_00_0_00_0_00_0_0_0_1_0;
    localparam logic [13:0] V_RST_MW = 14'b1_00_0_00_0_00_0_0_0_1_0;
    localparam logic [13:0] V_RT_NU  = 14'b0_01_1_10_0_10_1_1_0_0_0;
    localparam logic [13:0] V_NO_WR  = 14'b0_10_1_00_0_10_1_0_0_0_0;
    localparam logic [13:0] V_RT_LU  = 14'b0_00_0_11_1_11_1_1_0_0_0;

    task automatic apply_vec(input logic [13:0] v);
        {rst, id_rs, id_uses_rs, id_rt, id_uses_rt, ex_rd,
         ex_mem_read, ex_reg_write, ex_branch_taken, mem_req, mem_ready} = v;
    endtask

    task automatic model_eval();
        logic act;
        m_lu = ex_mem_read && ex_reg_write &&
               ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
        m_mw = mem_req && !mem_ready;
        for (int k = 0; k < 3; k++) begin
            act = (m_left[k] > 0);
            if (rst)                  m_exp[k] = 8'b0000_1110;
            else if (m_mw)            m_exp[k] = {6'b000000, 1'b1, act};
            else if (act)             m_exp[k] = 8'b0001_0101;
            else if (ex_branch_taken) m_exp[k] = 8'b1001_1100;
            else if (m_lu)            m_exp[k] = 8'b0001_0100;
            else                      m_exp[k] = 8'b1111_0000;
        end
    endtask

    task automatic model_commit();
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_left[k]  = 0;
                m_stall[k] = 0;
            end else begin
                if (!m_exp[k][7] && m_stall[k] < 65535) m_stall[k]++;
                if (m_mw) begin
                end else if (m_left[k] > 0) begin
                    m_left[k]--;
                end else if (!ex_branch_taken && m_lu) begin
                    m_left[k] = k; // LOAD_BUBBLES-1 further bubbles
                end
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            apply_vec(V_RST);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL reset_outputs lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
                if (i == 1) begin
                    checks++;
                    if (w_stall[k] !== 16'd0) begin
                        failures++;
                        $display("FAIL reset_stall lb=%0d got=%0d exp=0", k+1, w_stall[k]);
                    end
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        logic [13:0] seq [$] = '{V_RST, V_LU, V_IDLE, V_IDLE, V_IDLE, V_RT_LU, V_IDLE, V_IDLE, V_IDLE};
        for (int i = 0; i < seq.size(); i++) begin
            apply_vec(seq[i]);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL load_use_out lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
                checks++;
                if (w_stall[k] !== 16'(m_stall[k])) begin
                    failures++;
                    $display("FAIL load_use_stall lb=%0d cyc=%0d got=%0d exp=%0d", k+1, i, w_stall[k], m_stall[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
            // After the first hazard each instance has stalled LOAD_BUBBLES cycles.
            if (i == 4) begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (w_stall[k] !== 16'(k + 1)) begin
                        failures++;
                        $display("FAIL load_use_count lb=%0d got=%0d exp=%0d", k+1, w_stall[k], k+1);
                    end
                end
            end
        end
    endtask

    task automatic test_branch_priority();
        logic [13:0] seq [$] = '{V_RST, V_LU_BR, V_IDLE, V_LU_BR, V_IDLE};
        for (int i = 0; i < seq.size(); i++) begin
            apply_vec(seq[i]);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL branch_out lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'd0) begin
                failures++;
                $display("FAIL branch_stall lb=%0d got=%0d exp=0", k+1, w_stall[k]);
            end
        end
    endtask

    task automatic test_mem_wait_in_stall();
        logic [13:0] seq [$] = '{V_RST, V_LU, V_MW, V_MW, V_MW, V_MW, V_IDLE, V_IDLE, V_IDLE};
        int exp_cnt [3] = '{5, 6, 7};
        for (int i = 0; i < seq.size(); i++) begin
            apply_vec(seq[i]);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL memwait_out lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
                checks++;
                if (w_stall[k] !== 16'(m_stall[k])) begin
                    failures++;
                    $display("FAIL memwait_stall lb=%0d cyc=%0d got=%0d exp=%0d", k+1, i, w_stall[k], m_stall[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
        // Hazard cycle, four frozen cycles, then the remaining bubbles.
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'(exp_cnt[k])) begin
                failures++;
                $display("FAIL memwait_count lb=%0d got=%0d exp=%0d", k+1, w_stall[k], exp_cnt[k]);
            end
        end
    endtask

    task automatic test_no_false_hazard();
        logic [13:0] seq [$] = '{V_RST, V_RT_NU, V_NO_WR, V_IDLE};
        for (int i = 0; i < seq.size(); i++) begin
            apply_vec(seq[i]);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL nohazard_out lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'd0) begin
                failures++;
                $display("FAIL nohazard_stall lb=%0d got=%0d exp=0", k+1, w_stall[k]);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [13:0] seq [$] = '{V_RST, V_LU, V_RST, V_IDLE, V_LU, V_MW, V_RST_MW, V_IDLE, V_IDLE};
        for (int i = 0; i < seq.size(); i++) begin
            apply_vec(seq[i]);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL rstabort_out lb=%0d cyc=%0d got=%b exp=%b", k+1, i, w_out[k], m_exp[k]);
                end
                checks++;
                if (w_stall[k] !== 16'(m_stall[k])) begin
                    failures++;
                    $display("FAIL rstabort_stall lb=%0d cyc=%0d got=%0d exp=%0d", k+1, i, w_stall[k], m_stall[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        logic [13:0] v;
        for (int i = 0; i < 1500; i++) begin
            v[13]    = ($urandom_range(0, 39) == 0);
            v[12:11] = 2'($urandom_range(0, 3));
            v[10]    = 1'($urandom_range(0, 1));
            v[9:8]   = 2'($urandom_range(0, 3));
            v[7]     = 1'($urandom_range(0, 1));
            v[6:5]   = 2'($urandom_range(0, 3));
            v[4]     = 1'($urandom_range(0, 1));
            v[3]     = 1'($urandom_range(0, 1));
            v[2]     = ($urandom_range(0, 5) == 0);
            v[1]     = ($urandom_range(0, 2) == 0);
            v[0]     = 1'($urandom_range(0, 1));
            apply_vec(v);
            @(negedge clk);
            model_eval();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (w_out[k] !== m_exp[k]) begin
                    failures++;
                    $display("FAIL random_out lb=%0d cyc=%0d vec=%b got=%b exp=%b", k+1, i, v, w_out[k], m_exp[k]);
                end
                checks++;
                if (w_stall[k] !== 16'(m_stall[k])) begin
                    failures++;
                    $display("FAIL random_stall lb=%0d cyc=%0d got=%0d exp=%0d", k+1, i, w_stall[k], m_stall[k]);
                end
            end
            model_commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_saturation();
        apply_vec(V_RST);
        @(negedge clk); model_eval(); model_commit();
        @(posedge clk); #1;
        for (int i = 0; i < 65540; i++) begin
            apply_vec(V_MW);
            @(negedge clk); model_eval(); model_commit();
            @(posedge clk); #1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_hold lb=%0d got=%h exp=ffff", k+1, w_stall[k]);
            end
        end
        apply_vec(V_LU);
        @(negedge clk); model_eval(); model_commit();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'hFFFF) begin
                failures++;
                $display("FAIL sat_hold2 lb=%0d got=%h exp=ffff", k+1, w_stall[k]);
            end
        end
        apply_vec(V_RST);
        @(negedge clk); model_eval(); model_commit();
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (w_stall[k] !== 16'd0) begin
                failures++;
                $display("FAIL sat_clear lb=%0d got=%h exp=0", k+1, w_stall[k]);
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            m_left[k]  = 0;
            m_stall[k] = 0;
        end
        apply_vec(V_RST);
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait_in_stall();
        test_no_false_hazard();
        test_reset_abort();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
